// File: rtl/seg_scan_if.sv
// Display-side bundle of seg_scan_ctrl: the load handshake, the word to show,
// and the multiplexed cathode/anode pins.
interface seg_scan_if;
    logic        enable;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        load_ack;
    logic        frame_done;
    logic [6:0]  seg;
    logic        dp_n;
    logic [7:0]  an_n;

    modport master (
        output enable, value_in, dp_in, load,
        input  load_ack, frame_done, seg, dp_n, an_n
    );

    modport slave (
        input  enable, value_in, dp_in, load,
        output load_ack, frame_done, seg, dp_n, an_n
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit 7-segment scan controller: prescaler, digit scheduler, guard
// blanking, leading-zero suppression and frame-aligned value loading.
module seg_scan_ctrl #(
    parameter int DIV      = 25000,
    parameter int BLANK_LZ = 1
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int            CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   act_val;
    logic [7:0]    act_dp;
    logic [31:0]   pend_val;
    logic [7:0]    pend_dp;
    logic          pend;

    logic          boundary;
    logic          take;
    logic [7:0]    blank;
    logic [3:0]    nib;
    logic          lit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        // NOTE: default assigned before the case so no path leaves s unassigned.
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A digit goes dark only when it and everything left of it is zero and
    // its own decimal point is off; the rightmost digit always shows.
    assign blank[0] = 1'b0;
    for (genvar k = 1; k < 8; k++) begin : g_lz
        assign blank[k] = (BLANK_LZ != 0)
                       && ((act_val >> (4 * k)) == 32'd0)
                       && !act_dp[k];
    end

    assign nib      = act_val[{idx, 2'b00} +: 4];
    assign lit      = bus.enable && (cnt != '0) && !blank[idx];
    assign boundary = bus.enable && (idx == 3'd7) && (cnt == CNT_LAST);
    // While dark there is no frame to protect, so transfers happen at once.
    assign take     = boundary || !bus.enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            idx            <= '0;
            act_val        <= '0;
            act_dp         <= '0;
            pend_val       <= '0;
            pend_dp        <= '0;
            pend           <= 1'b0;
            bus.seg        <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.an_n       <= 8'hFF;
            bus.load_ack   <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge state.
            if (bus.enable) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    idx <= idx + 3'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            // A load on a transfer edge supersedes anything still pending.
            if (take && bus.load) begin
                act_val <= bus.value_in;
                act_dp  <= bus.dp_in;
                pend    <= 1'b0;
            end else if (take && pend) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
                pend    <= 1'b0;
            end else if (bus.load) begin
                pend_val <= bus.value_in;
                pend_dp  <= bus.dp_in;
                pend     <= 1'b1;
            end

            bus.load_ack   <= take && (bus.load || pend);
            bus.frame_done <= boundary;

            // First cycle of each slot stays dark to hide anode switching ghosts.
            if (lit) begin
                bus.an_n <= ~(8'b1 << idx);
                bus.seg  <= hex7(nib);
                bus.dp_n <= ~act_dp[idx];
            end else begin
                bus.an_n <= 8'hFF;
                bus.seg  <= 7'h7F;
                bus.dp_n <= 1'b1;
            end
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scheduler that shares the board's single 7-segment cathode bus among the eight digit anodes, so the CPU top can display a 32-bit word as eight hex digits. It sits between the CPU's result/PC register and the `a..g`, `dp`, `d0..d7` pins. It owns the scan prescaler, the digit scheduler, anti-ghost guard blanking and leading-zero suppression. A load/ack handshake updates the displayed value only at frame boundaries, so a frame never mixes two values.

## Interface
- `DIV`, 25000: clock cycles per digit slot (0.5 ms at 50 MHz); legal values ≥ 2.
- `BLANK_LZ`, 1: 1 enables leading-zero suppression; 0 shows all eight digits.

Ports:
- `clk` in 1: system clock, single domain.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: 1 = scanning; 0 = display dark.
- `value_in` in 32: word to display; nibble k drives digit k, and digit 0 is rightmost.
- `dp_in` in 8: decimal point per digit; bit k belongs to digit k; 1 = lit. Sampled together with `value_in`.
- `load` in 1: one-cycle request to display `value_in`/`dp_in`.
- `load_ack` out 1: one-cycle pulse when the loaded value becomes active.
- `frame_done` out 1: one-cycle pulse at each frame boundary.
- `seg` out 7: cathodes {g,f,e,d,c,b,a}, active-low.
- `dp_n` out 1: decimal-point cathode, active-low.
- `an_n` out 8: anodes {d7..d0}, active-low; at most one bit is low at a time.

## Operation
- State:
  - `cnt` runs 0..DIV-1.
  - `idx` runs 0..7.
  - `act_val`/`act_dp` hold the displayed value.
  - `pend_val`/`pend_dp`/`pend` hold the requested value.
- Scheduler:
  - While `enable`=1, `cnt` increments each cycle.
  - At `cnt`=DIV-1, `cnt`→0 and `idx`→`idx`+1, wrapping 7→0.
  - A boundary is the cycle with `idx`=7 and `cnt`=DIV-1.
- Load:
  - `load`=1 captures `value_in`/`dp_in` into the pending register and sets `pend`.
  - A second `load` before the transfer overwrites the pending value; the latest value wins and only one ack is produced.
- Transfer: at a boundary with `pend`=1, pending moves to active, `pend` clears, and `load_ack` pulses.
- `load` on the boundary cycle itself: `value_in` goes straight to active that edge, with one ack.
- Disabled (`enable`=0):
  - `cnt` and `idx` hold.
  - A pending value transfers on the next edge, with the ack following that edge.
- Output per (`idx`,`cnt`) state:
  - Guard: when `cnt`=0, or `enable`=0, or the digit is blanked, output `an_n`=FF, `seg`=7F, `dp_n`=1.
  - Otherwise, `an_n` has only bit `idx` low, `seg` = hex(nibble `idx`), and `dp_n` = ~`act_dp[idx]`.
- Hex codes (g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (`BLANK_LZ`=1):
  - Digit k is blanked if every nibble ≥k is zero and `act_dp[k]`=0.
  - Digit 0 is never blanked.

## Timing
- All outputs are registered. The value at edge t reflects the state before edge t, so latency is one cycle.
- Each slot is DIV cycles: 1 guard cycle, then DIV-1 lit cycles. A frame is 8·DIV cycles.
- Reset values:
  - Outputs: `seg`=7F, `dp_n`=1, `an_n`=FF, `load_ack`=0, `frame_done`=0.
  - State: `cnt`=0, `idx`=0, `act`=0, `pend`=0.
- After reset, the first edge with `rst` low shows the guard; digit 0 is lit from the second edge.
- `frame_done` and `load_ack` go high for exactly one cycle, both registered from the boundary edge.
- `rst` mid-frame takes effect at the next edge. Pending and active values are discarded, and no ack is issued.
- `rst` has priority over `load` and `enable`.

## Test plan
All scenarios use DIV=4 and BLANK_LZ=1.
- Reset, `enable`=1, no load:
  - Each frame shows only digit 0 lit, with `an_n`=FE and `seg`=40, for 3 cycles of every 32.
  - All other cycles show `an_n`=FF.
  - `frame_done` pulses every 32 cycles.
- `load` with `value_in`=0x00001234 and `dp_in`=0x02:
  - `load_ack` pulses once, at most 32 cycles later.
  - The next frame shows digit0=19, digit1=30 with `dp_n`=0, digit2=24, digit3=79.
  - Digits 4–7 stay dark.
- Two loads in one frame, 0x11 then 0xAB:
  - Exactly one ack.
  - The frame shows digit0=03 and digit1=08; 0x11 never appears.
- `load` of 0xF0000000 on the boundary cycle:
  - Ack on the following cycle.
  - The next frame lights all digits: digits 0–6 show 40, digit 7 shows 0E.
- `enable`=0 mid-slot:
  - Next edge gives `an_n`=FF and `seg`=7F.
  - A load while disabled acks after one edge.
  - Re-enabling resumes at the held `idx`/`cnt`.
- `rst` pulse during digit 5 with a value active:
  - Next edge restores all reset values and no ack is issued.
  - The following frame shows only digit 0 = 40.
